// File: rtl/reg_write_port_pkg.sv
// Shared defaults and the write-queue entry type for the register write port.
package reg_write_port_pkg;

  localparam int DW_DEF    = 16;
  localparam int AW_DEF    = 4;
  localparam int DEPTH_DEF = 4;

  typedef struct packed {
    logic [AW_DEF-1:0] reg_idx;
    logic [DW_DEF-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_queue.sv
// Circular write queue: DEPTH entries of {reg, data}, wrapping pointers and an
// occupancy counter. All entry storage is exposed so the parent can search it.
module wb_queue
  import reg_write_port_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int AW    = AW_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int PW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      push_i,
  input  logic [AW-1:0]             push_reg_i,
  input  logic [DW-1:0]             push_data_i,
  input  logic                      pop_i,
  output logic                      full_o,
  output logic                      empty_o,
  output logic [AW-1:0]             head_reg_o,
  output logic [DW-1:0]             head_data_o,
  output logic [PW-1:0]             rd_ptr_o,
  output logic [CW-1:0]             count_o,
  output logic [DEPTH-1:0][AW-1:0]  ent_reg_o,
  output logic [DEPTH-1:0][DW-1:0]  ent_data_o
);

  logic [PW-1:0]            wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]            rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]            count_q, count_d;
  logic [DEPTH-1:0][AW-1:0] reg_q;
  logic [DEPTH-1:0][DW-1:0] data_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
    unique case ({push_i, pop_i})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Entry fields are cleared on reset so an idle port presents reg 0 / data 0.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      reg_q    <= '0;
      data_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_i) begin
        reg_q[wr_ptr_q]  <= push_reg_i;
        data_q[wr_ptr_q] <= push_data_i;
      end
    end
  end

  assign full_o      = (count_q == CW'(DEPTH));
  assign empty_o     = (count_q == '0);
  assign head_reg_o  = reg_q[rd_ptr_q];
  assign head_data_o = data_q[rd_ptr_q];
  assign rd_ptr_o    = rd_ptr_q;
  assign count_o     = count_q;
  assign ent_reg_o   = reg_q;
  assign ent_data_o  = data_q;

endmodule

// File: rtl/reg_write_port.sv
// Buffered register-heap write port with busy detection and youngest-entry
// forwarding for two decode-stage source registers.
module reg_write_port
  import reg_write_port_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int AW    = AW_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          wb_valid_i,
  input  logic [AW-1:0] wb_reg_i,
  input  logic [DW-1:0] wb_data_i,
  output logic          wb_ready_o,
  input  logic          drain_en_i,
  output logic          regwrite_o,
  output logic [AW-1:0] wrreg_o,
  output logic [DW-1:0] wdata_o,
  input  logic [AW-1:0] rdreg1_i,
  input  logic [AW-1:0] rdreg2_i,
  output logic          busy1_o,
  output logic          busy2_o,
  output logic [DW-1:0] fwd1_data_o,
  output logic [DW-1:0] fwd2_data_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic                     push, pop, full, empty;
  logic [PW-1:0]            rd_ptr;
  logic [CW-1:0]            count;
  logic [DEPTH-1:0][AW-1:0] ent_reg;
  logic [DEPTH-1:0][DW-1:0] ent_data;
  logic [PW-1:0]            idx;

  // Handshake: a request transfers on a rising edge where wb_valid_i and
  // wb_ready_o are both high; the producer holds reg/data stable until then.
  // wb_ready_o depends only on occupancy, so a full queue refuses even while
  // it pops.
  assign wb_ready_o = !full;
  assign push       = wb_valid_i && wb_ready_o;
  assign regwrite_o = !empty && drain_en_i;
  assign pop        = regwrite_o;

  wb_queue #(
    .DW    (DW),
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk_i       (CLK),
    .rst_ni      (RST),
    .push_i      (push),
    .push_reg_i  (wb_reg_i),
    .push_data_i (wb_data_i),
    .pop_i       (pop),
    .full_o      (full),
    .empty_o     (empty),
    .head_reg_o  (wrreg_o),
    .head_data_o (wdata_o),
    .rd_ptr_o    (rd_ptr),
    .count_o     (count),
    .ent_reg_o   (ent_reg),
    .ent_data_o  (ent_data)
  );

  // Walk from oldest to newest so the last hit is the youngest matching write.
  always_comb begin
    busy1_o     = 1'b0;
    busy2_o     = 1'b0;
    fwd1_data_o = '0;
    fwd2_data_o = '0;
    idx         = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PW'(i);
      if (CW'(i) < count) begin
        if (ent_reg[idx] == rdreg1_i) begin
          busy1_o     = 1'b1;
          fwd1_data_o = ent_data[idx];
        end
        if (ent_reg[idx] == rdreg2_i) begin
          busy2_o     = 1'b1;
          fwd2_data_o = ent_data[idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_reg_write_port.sv
// Randomized and directed bench for reg_write_port against a queue-based model
// of pending heap writes.
module tb_reg_write_port;
  import reg_write_port_pkg::*;

  localparam int DW    = DW_DEF;
  localparam int AW    = AW_DEF;
  localparam int DEPTH = DEPTH_DEF;

  // ---------------- clock / reset ----------------
  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          wb_valid_i = 1'b0;
  logic [AW-1:0] wb_reg_i = '0;
  logic [DW-1:0] wb_data_i = '0;
  logic          drain_en_i = 1'b0;
  logic [AW-1:0] rdreg1_i = '0;
  logic [AW-1:0] rdreg2_i = '0;
  logic          wb_ready_o, regwrite_o, busy1_o, busy2_o;
  logic [AW-1:0] wrreg_o;
  logic [DW-1:0] wdata_o, fwd1_data_o, fwd2_data_o;

  always #5 CLK = ~CLK;

  reg_write_port #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .wb_valid_i  (wb_valid_i),
    .wb_reg_i    (wb_reg_i),
    .wb_data_i   (wb_data_i),
    .wb_ready_o  (wb_ready_o),
    .drain_en_i  (drain_en_i),
    .regwrite_o  (regwrite_o),
    .wrreg_o     (wrreg_o),
    .wdata_o     (wdata_o),
    .rdreg1_i    (rdreg1_i),
    .rdreg2_i    (rdreg2_i),
    .busy1_o     (busy1_o),
    .busy2_o     (busy2_o),
    .fwd1_data_o (fwd1_data_o),
    .fwd2_data_o (fwd2_data_o)
  );

  // ---------------- scoreboard / model ----------------
  // exp_q holds the writes still owed to the heap, oldest first.
  logic [AW+DW-1:0] exp_q[$];
  int  n_pass  = 0;
  int  n_total = 0;
  bit  fresh    = 1'b1;
  bit  last_acc = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic void model_match(input logic [AW-1:0] r, output logic b,
                                      output logic [DW-1:0] d);
    wb_entry_t e;
    b = 1'b0;
    d = '0;
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      e = wb_entry_t'(exp_q[i]);
      if (e.reg_idx == r) begin
        b = 1'b1;
        d = e.data;
        break;
      end
    end
  endfunction

  always @(posedge CLK) begin
    if (RST) begin
      bit push, pop;
      push = wb_valid_i && (exp_q.size() < DEPTH);
      pop  = (exp_q.size() != 0) && drain_en_i;
      last_acc = push;
      if (pop) void'(exp_q.pop_front());
      if (push) begin
        exp_q.push_back({wb_reg_i, wb_data_i});
        fresh = 1'b0;
      end
    end
  end

  always @(negedge RST) begin
    exp_q.delete();
    fresh    = 1'b1;
    last_acc = 1'b0;
  end

  task automatic compare_all();
    wb_entry_t     hd;
    logic          b1, b2;
    logic [DW-1:0] f1, f2;
    check("wb_ready", 32'(wb_ready_o), 32'(exp_q.size() < DEPTH));
    check("regwrite", 32'(regwrite_o), 32'((exp_q.size() != 0) && drain_en_i));
    if (exp_q.size() != 0) begin
      hd = wb_entry_t'(exp_q[0]);
      check("wrreg", 32'(wrreg_o), 32'(hd.reg_idx));
      check("wdata", 32'(wdata_o), 32'(hd.data));
    end else if (fresh) begin
      check("wrreg_idle", 32'(wrreg_o), 32'h0);
      check("wdata_idle", 32'(wdata_o), 32'h0);
    end
    model_match(rdreg1_i, b1, f1);
    model_match(rdreg2_i, b2, f2);
    check("busy1", 32'(busy1_o), 32'(b1));
    check("busy2", 32'(busy2_o), 32'(b2));
    check("fwd1", 32'(fwd1_data_o), 32'(f1));
    check("fwd2", 32'(fwd2_data_o), 32'(f2));
  endtask

  always @(negedge CLK) begin
    #2;
    compare_all();
  end

  // ---------------- driver tasks ----------------
  task automatic push_req(input logic [AW-1:0] r, input logic [DW-1:0] d);
    @(negedge CLK);
    wb_valid_i = 1'b1;
    wb_reg_i   = r;
    wb_data_i  = d;
  endtask

  task automatic idle_cycle();
    @(negedge CLK);
    wb_valid_i = 1'b0;
  endtask

  task automatic drain_all();
    @(negedge CLK);
    wb_valid_i = 1'b0;
    drain_en_i = 1'b1;
    repeat (DEPTH + 1) @(negedge CLK);
    drain_en_i = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    @(negedge CLK);
    #3;
    check("rst_ready", 32'(wb_ready_o), 32'h1);
    check("rst_regwrite", 32'(regwrite_o), 32'h0);
    check("rst_wrreg", 32'(wrreg_o), 32'h0);
    @(negedge CLK);
    RST = 1'b1;

    // single write straight through to the heap
    drain_en_i = 1'b1;
    push_req(4'd8, 16'hF0F0);
    idle_cycle();
    #3;
    check("pass_regwrite", 32'(regwrite_o), 32'h1);
    check("pass_wrreg", 32'(wrreg_o), 32'h8);
    check("pass_wdata", 32'(wdata_o), 32'hF0F0);
    @(negedge CLK);
    #3;
    check("pass_empty", 32'(regwrite_o), 32'h0);
    drain_en_i = 1'b0;

    // two writes to one register: newest forwarded, both drained in order
    push_req(4'd3, 16'hABCD);
    push_req(4'd3, 16'hDDDD);
    idle_cycle();
    rdreg1_i = 4'd3;
    #3;
    check("dup_busy1", 32'(busy1_o), 32'h1);
    check("dup_fwd1", 32'(fwd1_data_o), 32'hDDDD);
    drain_en_i = 1'b1;
    #1;
    check("dup_first", 32'(wdata_o), 32'hABCD);
    @(negedge CLK);
    #3;
    check("dup_second", 32'(wdata_o), 32'hDDDD);
    check("dup_fwd_still", 32'(fwd1_data_o), 32'hDDDD);
    @(negedge CLK);
    #3;
    check("dup_done_busy", 32'(busy1_o), 32'h0);
    check("dup_done_fwd", 32'(fwd1_data_o), 32'h0);
    drain_en_i = 1'b0;

    // full queue holds off a fifth request until one entry drains
    push_req(4'd1, 16'h1111);
    push_req(4'd2, 16'h2222);
    push_req(4'd5, 16'h5555);
    push_req(4'd6, 16'h6666);
    push_req(4'd7, 16'h7777);
    #3;
    check("full_ready", 32'(wb_ready_o), 32'h0);
    @(negedge CLK);
    #3;
    check("full_held", 32'(wb_ready_o), 32'h0);
    drain_en_i = 1'b1;
    @(negedge CLK);
    drain_en_i = 1'b0;
    #3;
    check("full_popped", 32'(wb_ready_o), 32'h1);
    check("full_head", 32'(wrreg_o), 32'h2);
    idle_cycle();
    #3;
    check("full_again", 32'(wb_ready_o), 32'h0);
    drain_all();

    // simultaneous push and pop
    push_req(4'd10, 16'hAAAA);
    push_req(4'd11, 16'hBBBB);
    push_req(4'd9, 16'h1234);
    drain_en_i = 1'b1;
    idle_cycle();
    drain_en_i = 1'b0;
    rdreg1_i = 4'd9;
    rdreg2_i = 4'd10;
    #3;
    check("pp_head", 32'(wrreg_o), 32'd11);
    check("pp_busy_new", 32'(busy1_o), 32'h1);
    check("pp_fwd_new", 32'(fwd1_data_o), 32'h1234);
    check("pp_busy_gone", 32'(busy2_o), 32'h0);
    drain_en_i = 1'b1;
    @(negedge CLK);
    #3;
    check("pp_next_reg", 32'(wrreg_o), 32'd9);
    check("pp_next_data", 32'(wdata_o), 32'h1234);
    drain_all();

    // reset discards queued writes mid-drain
    push_req(4'd1, 16'h0101);
    push_req(4'd2, 16'h0202);
    push_req(4'd3, 16'h0303);
    idle_cycle();
    drain_en_i = 1'b1;
    rdreg1_i   = 4'd1;
    rdreg2_i   = 4'd3;
    #1;
    RST = 1'b0;
    #1;
    check("rstq_regwrite", 32'(regwrite_o), 32'h0);
    check("rstq_busy1", 32'(busy1_o), 32'h0);
    check("rstq_busy2", 32'(busy2_o), 32'h0);
    check("rstq_ready", 32'(wb_ready_o), 32'h1);
    check("rstq_wdata", 32'(wdata_o), 32'h0);
    @(negedge CLK);
    RST = 1'b1;
    #3;
    check("rstq_after1", 32'(regwrite_o), 32'h0);
    @(negedge CLK);
    #3;
    check("rstq_after2", 32'(regwrite_o), 32'h0);
    drain_en_i = 1'b0;

    // one port hits, the other misses
    push_req(4'd8, 16'h5A5A);
    idle_cycle();
    rdreg1_i = 4'd8;
    rdreg2_i = 4'd9;
    #3;
    check("hm_busy1", 32'(busy1_o), 32'h1);
    check("hm_fwd1", 32'(fwd1_data_o), 32'h5A5A);
    check("hm_busy2", 32'(busy2_o), 32'h0);
    check("hm_fwd2", 32'(fwd2_data_o), 32'h0);
    drain_all();

    // randomized traffic; the producer holds a refused request
    for (int c = 0; c < 800; c++) begin
      @(negedge CLK);
      RST = 1'b1;
      if (!(wb_valid_i && !last_acc)) begin
        wb_valid_i = ($urandom_range(0, 99) < 60);
        wb_reg_i   = AW'($urandom_range(0, 15));
        wb_data_i  = DW'($urandom);
      end
      drain_en_i = ($urandom_range(0, 99) < ((c < 400) ? 35 : 75));
      if (exp_q.size() != 0 && $urandom_range(0, 1) == 1)
        rdreg1_i = AW'(exp_q[$urandom_range(0, exp_q.size() - 1)] >> DW);
      else
        rdreg1_i = AW'($urandom_range(0, 15));
      if (exp_q.size() != 0 && $urandom_range(0, 1) == 1)
        rdreg2_i = AW'(exp_q[$urandom_range(0, exp_q.size() - 1)] >> DW);
      else
        rdreg2_i = AW'($urandom_range(0, 15));
      if (c == 500) begin
        #4;
        RST = 1'b0;
      end
    end

    @(negedge CLK);
    wb_valid_i = 1'b0;
    drain_en_i = 1'b0;
    @(negedge CLK);
    #4;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
